// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO management responder (PHY side).
// MDC and MDIO are oversampled on clk_clk through 2-flop synchronisers. Frames addressed to
// PHY_ADDR (and broadcast writes to PHYAD 0 when BCAST_EN) access a small 16-bit register file.
// Ports:
//   clk_clk, reset_reset_n   system clock, async active-low reset
//   mdc, mdio_i              management clock and MDIO pin value from the station manager
//   mdio_o, mdio_oe          MDIO drive value / drive enable (1 = drive)
//   status_in                live value returned for register 1
//   ctrl_out, soft_reset     register 0 contents, one-clk pulse when reg0 bit 15 is written 1
//   scratch_out              registers 7..4, register 4 in bits [15:0]
//   err_count                saturating count of aborted frames
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter bit          BCAST_EN     = 1'b1,
  parameter logic [15:0] PHY_ID1      = 16'h0141,
  parameter logic [15:0] PHY_ID2      = 16'h0DD1,
  parameter int unsigned PREAMBLE_LEN = 32,
  parameter int unsigned TIMEOUT_CYC  = 4096
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic [15:0] status_in,
  output logic [15:0] ctrl_out,
  output logic        soft_reset,
  output logic [63:0] scratch_out,
  output logic [7:0]  err_count
);

  localparam int unsigned PreW = $clog2(PREAMBLE_LEN + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [PreW-1:0] PreMax = PreW'(PREAMBLE_LEN);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    StIdle, StSt1, StOp, StPhyad, StRegad, StTa, StWdata, StRdata
  } state_e;

  logic            mdc_s1_q, mdc_s2_q, mdc_prev_q, mdio_s1_q, mdio_s2_q;
  logic            mdc_edge, bit_s;
  state_e          state_q, state_d;
  logic [PreW-1:0] pre_q, pre_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [14:0]     sh_q, sh_d;
  logic            is_wr_q, is_wr_d;
  logic [4:0]      phyad_q, phyad_d, regad_q, regad_d;
  logic [15:0]     rdata_q, rdata_d;
  logic            oe_q, oe_d, o_q, o_d;
  logic [15:0]     ctrl_q, ctrl_d;
  logic [63:0]     scratch_q, scratch_d;
  logic            srst_q, srst_d;
  logic [7:0]      err_q, err_d;
  logic            match, abort;
  logic [4:0]      field5;
  logic [15:0]     word16, rd_val;

  assign mdc_edge = mdc_s2_q & ~mdc_prev_q;
  assign bit_s    = mdio_s2_q;
  // Field values including the bit being sampled on this edge.
  assign field5   = {sh_q[3:0], bit_s};
  assign word16   = {sh_q, bit_s};
  assign match    = (phyad_q == PHY_ADDR) || (BCAST_EN && (phyad_q == 5'd0) && is_wr_q);

  always_comb begin
    rd_val = '0;
    case (field5)
      5'd0:                      rd_val = ctrl_q;
      5'd1:                      rd_val = status_in;
      5'd2:                      rd_val = PHY_ID1;
      5'd3:                      rd_val = PHY_ID2;
      5'd4, 5'd5, 5'd6, 5'd7:    rd_val = scratch_q[{field5[1:0], 4'b0000} +: 16];
      default:                   rd_val = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    tmo_d     = tmo_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    is_wr_d   = is_wr_q;
    phyad_d   = phyad_q;
    regad_d   = regad_q;
    rdata_d   = rdata_q;
    oe_d      = oe_q;
    o_d       = o_q;
    ctrl_d    = ctrl_q;
    scratch_d = scratch_q;
    srst_d    = 1'b0;
    err_d     = err_q;
    abort     = 1'b0;

    if (state_q == StIdle) begin
      tmo_d = '0;
    end else if (mdc_edge) begin
      tmo_d = '0;
    end else if (tmo_q == TmoMax) begin
      abort = 1'b1;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end

    if (mdc_edge) begin
      case (state_q)
        StIdle: begin
          if (bit_s) begin
            if (pre_q != PreMax) pre_d = pre_q + 1'b1;
          end else begin
            if (pre_q == PreMax) state_d = StSt1;
            pre_d = '0;
          end
        end
        StSt1: begin
          if (bit_s) begin
            state_d = StOp;
            cnt_d   = '0;
          end else begin
            abort = 1'b1;
          end
        end
        StOp: begin
          sh_d  = {sh_q[13:0], bit_s};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == 5'd1) begin
            cnt_d   = '0;
            state_d = StPhyad;
            case ({sh_q[0], bit_s})
              2'b10:   is_wr_d = 1'b0;
              2'b01:   is_wr_d = 1'b1;
              default: abort   = 1'b1;
            endcase
          end
        end
        StPhyad: begin
          sh_d  = {sh_q[13:0], bit_s};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == 5'd4) begin
            phyad_d = field5;
            cnt_d   = '0;
            state_d = StRegad;
          end
        end
        StRegad: begin
          sh_d  = {sh_q[13:0], bit_s};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == 5'd4) begin
            regad_d = field5;
            rdata_d = rd_val;
            cnt_d   = '0;
            state_d = StTa;
          end
        end
        StTa: begin
          if (!is_wr_q) begin
            // End of TA bit 1: start driving the TA 0 bit.
            state_d = StRdata;
            cnt_d   = '0;
            if (match) begin
              oe_d = 1'b1;
              o_d  = 1'b0;
            end
          end else if (cnt_q == 5'd0) begin
            if (bit_s) cnt_d = 5'd1;
            else       abort = 1'b1;
          end else begin
            if (!bit_s) begin
              state_d = StWdata;
              cnt_d   = '0;
            end else begin
              abort = 1'b1;
            end
          end
        end
        StWdata: begin
          sh_d  = {sh_q[13:0], bit_s};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == 5'd15) begin
            if (match) begin
              if (regad_q == 5'd0) begin
                ctrl_d = {1'b0, word16[14:0]};
                srst_d = word16[15];
              end else if (regad_q[4:2] == 3'b001) begin
                scratch_d[{regad_q[1:0], 4'b0000} +: 16] = word16;
              end
            end
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
        StRdata: begin
          if (cnt_q == 5'd16) begin
            oe_d    = 1'b0;
            o_d     = 1'b1;
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            if (match) o_d = rdata_q[15];
            rdata_d = {rdata_q[14:0], 1'b0};
            cnt_d   = cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (abort) begin
      state_d = StIdle;
      oe_d    = 1'b0;
      o_d     = 1'b1;
      pre_d   = '0;
      cnt_d   = '0;
      tmo_d   = '0;
      if (err_q != 8'hFF) err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      mdc_s1_q   <= 1'b0;
      mdc_s2_q   <= 1'b0;
      mdc_prev_q <= 1'b0;
      mdio_s1_q  <= 1'b1;
      mdio_s2_q  <= 1'b1;
      state_q    <= StIdle;
      pre_q      <= '0;
      tmo_q      <= '0;
      cnt_q      <= '0;
      sh_q       <= '0;
      is_wr_q    <= 1'b0;
      phyad_q    <= '0;
      regad_q    <= '0;
      rdata_q    <= '0;
      oe_q       <= 1'b0;
      o_q        <= 1'b1;
      ctrl_q     <= 16'h1140;
      scratch_q  <= '0;
      srst_q     <= 1'b0;
      err_q      <= '0;
    end else begin
      mdc_s1_q   <= mdc;
      mdc_s2_q   <= mdc_s1_q;
      mdc_prev_q <= mdc_s2_q;
      mdio_s1_q  <= mdio_i;
      mdio_s2_q  <= mdio_s1_q;
      state_q    <= state_d;
      pre_q      <= pre_d;
      tmo_q      <= tmo_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      is_wr_q    <= is_wr_d;
      phyad_q    <= phyad_d;
      regad_q    <= regad_d;
      rdata_q    <= rdata_d;
      oe_q       <= oe_d;
      o_q        <= o_d;
      ctrl_q     <= ctrl_d;
      scratch_q  <= scratch_d;
      srst_q     <= srst_d;
      err_q      <= err_d;
    end
  end

  assign mdio_o      = o_q;
  assign mdio_oe     = oe_q;
  assign ctrl_out    = ctrl_q;
  assign soft_reset  = srst_q;
  assign scratch_out = scratch_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Bench for mdio_phy_responder: directed vector table, hand-written corner sequences
// (timeout, short preamble, reset mid-read) and random frames against a register-level model.
module tb_mdio_phy_responder;

  logic        clk_clk       = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        mdc           = 1'b0;
  logic        mdio_i        = 1'b1;
  logic [15:0] status_in     = 16'hBEEF;
  logic        mdio_o, mdio_oe, soft_reset;
  logic [15:0] ctrl_out;
  logic [63:0] scratch_out;
  logic [7:0]  err_count;

  mdio_phy_responder dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .mdc           (mdc),
    .mdio_i        (mdio_i),
    .mdio_o        (mdio_o),
    .mdio_oe       (mdio_oe),
    .status_in     (status_in),
    .ctrl_out      (ctrl_out),
    .soft_reset    (soft_reset),
    .scratch_out   (scratch_out),
    .err_count     (err_count)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic [1:0]  ta;
    logic [15:0] wd;
    bit          drv;
    logic [15:0] rd;
    logic [7:0]  err;
    logic [15:0] ctrl;
    logic [63:0] scr;
    int          pulses;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  logic bitq[$];
  logic smp_oe[$];
  logic smp_o[$];
  int   srst_pulses = 0;
  int   srst_long   = 0;
  logic srst_prev   = 1'b0;

  logic [15:0] m_ctrl;
  logic [15:0] m_scr[4];
  logic [7:0]  m_err;
  int          m_pulses;

  // Soft-reset pulse monitor: counts pulses and flags any pulse wider than one clock.
  always @(negedge clk_clk) begin
    srst_prev <= soft_reset;
    if (soft_reset && !srst_prev) srst_pulses <= srst_pulses + 1;
    if (soft_reset && srst_prev)  srst_long   <= srst_long + 1;
  end

  function automatic vec_t mk(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] rg,
                              input logic [1:0] ta, input logic [15:0] wd, input bit drv,
                              input logic [15:0] rd, input logic [7:0] err,
                              input logic [15:0] ctrl, input logic [63:0] scr, input int pulses);
    vec_t v;
    v.op = op; v.phy = phy; v.rg = rg; v.ta = ta; v.wd = wd; v.drv = drv; v.rd = rd;
    v.err = err; v.ctrl = ctrl; v.scr = scr; v.pulses = pulses;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_bits(input logic [15:0] v, input int w);
    for (int i = w - 1; i >= 0; i--) bitq.push_back(v[i]);
  endtask

  // Station-side frame; read frames leave the line released (1) for TA and data.
  task automatic build(input int pre, input logic [1:0] op, input logic [4:0] phy,
                       input logic [4:0] rg, input logic [1:0] ta, input logic [15:0] wd);
    bitq.delete();
    for (int i = 0; i < pre; i++) bitq.push_back(1'b1);
    push_bits(16'b01, 2);
    push_bits({14'd0, op}, 2);
    push_bits({11'd0, phy}, 5);
    push_bits({11'd0, rg}, 5);
    if (op == 2'b01) begin
      push_bits({14'd0, ta}, 2);
      push_bits(wd, 16);
    end else begin
      push_bits(16'hFFFF, 16);
      push_bits(16'h0003, 2);
    end
    bitq.push_back(1'b1);
  endtask

  // One MDC period per bit; outputs sampled at the end of the low phase.
  task automatic play(input int n);
    smp_oe.delete();
    smp_o.delete();
    for (int i = 0; i < n; i++) begin
      mdio_i = bitq[i];
      #48;
      smp_oe.push_back(mdio_oe);
      smp_o.push_back(mdio_o);
      #2 mdc = 1'b1;
      #50 mdc = 1'b0;
    end
  endtask

  task automatic frame_check(input string tag, input int pre, input logic [1:0] op,
                             input logic [4:0] phy, input logic [4:0] rg, input logic [1:0] ta,
                             input logic [15:0] wd, input bit exp_drv, input logic [15:0] exp_rd);
    int          b;
    logic        any_oe, early_oe, all_oe;
    logic [15:0] rd;
    build(pre, op, phy, rg, ta, wd);
    play(bitq.size());
    b        = pre + 14;
    any_oe   = 1'b0;
    early_oe = 1'b0;
    foreach (smp_oe[i]) begin
      any_oe = any_oe | smp_oe[i];
      if (i <= b) early_oe = early_oe | smp_oe[i];
    end
    if (exp_drv) begin
      all_oe = 1'b1;
      for (int k = 0; k < 16; k++) begin
        rd[15-k] = smp_o[b+2+k];
        all_oe   = all_oe & smp_oe[b+2+k];
      end
      check({tag, " early_oe"}, 64'(early_oe), 64'd0);
      check({tag, " ta2_oe_o"}, 64'({smp_oe[b+1], smp_o[b+1]}), 64'b10);
      check({tag, " rdata"}, 64'(rd), 64'(exp_rd));
      check({tag, " data_oe"}, 64'(all_oe), 64'd1);
      check({tag, " release"}, 64'({smp_oe[b+18], smp_o[b+18]}), 64'b01);
    end else begin
      check({tag, " no_drive"}, 64'(any_oe), 64'd0);
    end
  endtask

  task automatic check_state(input string tag, input logic [7:0] err, input logic [15:0] ctrl,
                             input logic [63:0] scr, input int pulses);
    check({tag, " err_count"}, 64'(err_count), 64'(err));
    check({tag, " ctrl_out"}, 64'(ctrl_out), 64'(ctrl));
    check({tag, " scratch_out"}, scratch_out, scr);
    check({tag, " srst_pulses"}, 64'(srst_pulses), 64'(pulses));
  endtask

  task automatic check_reset(input string tag);
    check({tag, " oe"}, 64'(mdio_oe), 64'd0);
    check({tag, " o"}, 64'(mdio_o), 64'd1);
    check({tag, " ctrl"}, 64'(ctrl_out), 64'h1140);
    check({tag, " scratch"}, scratch_out, 64'd0);
    check({tag, " srst"}, 64'(soft_reset), 64'd0);
    check({tag, " err"}, 64'(err_count), 64'd0);
  endtask

  function automatic logic [15:0] mread(input logic [4:0] r, input logic [15:0] st);
    if (r == 5'd0) return m_ctrl;
    if (r == 5'd1) return st;
    if (r == 5'd2) return 16'h0141;
    if (r == 5'd3) return 16'h0DD1;
    if (r < 5'd8)  return m_scr[r[1:0]];
    return 16'h0000;
  endfunction

  initial begin
    vec_t        vecs[$];
    vec_t        v;
    logic [1:0]  r_op, r_ta;
    logic [4:0]  r_phy, r_rg;
    logic [15:0] r_wd, r_exp;
    bit          r_drv;
    int          x;

    //              op     phy rg  ta     wd        drv rd        err ctrl      scratch                  pulses
    vecs.push_back(mk(2'b01, 1, 4, 2'b10, 16'hA5C3, 0, 16'h0000, 0, 16'h1140, 64'h0000_0000_0000_A5C3, 0));
    vecs.push_back(mk(2'b10, 1, 2, 2'b10, 16'h0000, 1, 16'h0141, 0, 16'h1140, 64'h0000_0000_0000_A5C3, 0));
    vecs.push_back(mk(2'b01, 1, 0, 2'b10, 16'h8000, 0, 16'h0000, 0, 16'h0000, 64'h0000_0000_0000_A5C3, 1));
    vecs.push_back(mk(2'b10, 1, 0, 2'b10, 16'h0000, 1, 16'h0000, 0, 16'h0000, 64'h0000_0000_0000_A5C3, 1));
    vecs.push_back(mk(2'b01, 0, 5, 2'b10, 16'h1234, 0, 16'h0000, 0, 16'h0000, 64'h0000_0000_1234_A5C3, 1));
    vecs.push_back(mk(2'b10, 0, 5, 2'b10, 16'h0000, 0, 16'h0000, 0, 16'h0000, 64'h0000_0000_1234_A5C3, 1));
    vecs.push_back(mk(2'b11, 1, 4, 2'b10, 16'h0000, 0, 16'h0000, 1, 16'h0000, 64'h0000_0000_1234_A5C3, 1));
    vecs.push_back(mk(2'b01, 1, 6, 2'b11, 16'hFFFF, 0, 16'h0000, 2, 16'h0000, 64'h0000_0000_1234_A5C3, 1));
    vecs.push_back(mk(2'b10, 1, 1, 2'b10, 16'h0000, 1, 16'hBEEF, 2, 16'h0000, 64'h0000_0000_1234_A5C3, 1));
    vecs.push_back(mk(2'b10, 1, 3, 2'b10, 16'h0000, 1, 16'h0DD1, 2, 16'h0000, 64'h0000_0000_1234_A5C3, 1));
    vecs.push_back(mk(2'b10, 1, 5, 2'b10, 16'h0000, 1, 16'h1234, 2, 16'h0000, 64'h0000_0000_1234_A5C3, 1));
    vecs.push_back(mk(2'b01, 1, 2, 2'b10, 16'hFFFF, 0, 16'h0000, 2, 16'h0000, 64'h0000_0000_1234_A5C3, 1));
    vecs.push_back(mk(2'b10, 1, 2, 2'b10, 16'h0000, 1, 16'h0141, 2, 16'h0000, 64'h0000_0000_1234_A5C3, 1));
    vecs.push_back(mk(2'b01, 1, 9, 2'b10, 16'h5555, 0, 16'h0000, 2, 16'h0000, 64'h0000_0000_1234_A5C3, 1));
    vecs.push_back(mk(2'b10, 1, 9, 2'b10, 16'h0000, 1, 16'h0000, 2, 16'h0000, 64'h0000_0000_1234_A5C3, 1));
    vecs.push_back(mk(2'b01, 3, 6, 2'b10, 16'h7777, 0, 16'h0000, 2, 16'h0000, 64'h0000_0000_1234_A5C3, 1));
    vecs.push_back(mk(2'b10, 1, 6, 2'b10, 16'h0000, 1, 16'h0000, 2, 16'h0000, 64'h0000_0000_1234_A5C3, 1));
    vecs.push_back(mk(2'b01, 1, 0, 2'b10, 16'h1234, 0, 16'h0000, 2, 16'h1234, 64'h0000_0000_1234_A5C3, 1));
    vecs.push_back(mk(2'b10, 1, 0, 2'b10, 16'h0000, 1, 16'h1234, 2, 16'h1234, 64'h0000_0000_1234_A5C3, 1));
    vecs.push_back(mk(2'b01, 1, 7, 2'b10, 16'hDEAD, 0, 16'h0000, 2, 16'h1234, 64'hDEAD_0000_1234_A5C3, 1));
    vecs.push_back(mk(2'b10, 3, 2, 2'b10, 16'h0000, 0, 16'h0000, 2, 16'h1234, 64'hDEAD_0000_1234_A5C3, 1));

    #20;
    check_reset("por");
    #12 reset_reset_n = 1'b1;
    #10;

    foreach (vecs[i]) begin
      v = vecs[i];
      frame_check($sformatf("vec%0d", i), 32, v.op, v.phy, v.rg, v.ta, v.wd, v.drv, v.rd);
      check_state($sformatf("vec%0d", i), v.err, v.ctrl, v.scr, v.pulses);
    end

    // MDC stalls mid-PHYAD: no abort after 2000 clocks, abort by 5000.
    build(32, 2'b10, 5'd1, 5'd2, 2'b10, 16'h0000);
    play(38);
    #20000;
    check("tmo_early err", 64'(err_count), 64'd2);
    #30000;
    check("tmo err", 64'(err_count), 64'd3);
    frame_check("tmo_after", 32, 2'b10, 5'd1, 5'd2, 2'b10, 16'h0000, 1, 16'h0141);

    // 31-bit preamble must not be accepted; a lone 0 first clears any leftover count.
    bitq.delete();
    bitq.push_back(1'b0);
    play(1);
    frame_check("pre31_rd", 31, 2'b10, 5'd1, 5'd2, 2'b10, 16'h0000, 0, 16'h0000);
    bitq.delete();
    bitq.push_back(1'b0);
    play(1);
    frame_check("pre31_wr", 31, 2'b01, 5'd1, 5'd7, 2'b10, 16'h0BAD, 0, 16'h0000);
    check_state("pre31", 8'd3, 16'h1234, 64'hDEAD_0000_1234_A5C3, 1);

    // Reset asserted while data bit 7 (a 0 in 16'h0141) is on the line.
    build(32, 2'b10, 5'd1, 5'd2, 2'b10, 16'h0000);
    play(56);
    #20;
    check("pre_rst oe_o", 64'({mdio_oe, mdio_o}), 64'b10);
    reset_reset_n = 1'b0;
    #1;
    check_reset("midrst");
    #29 reset_reset_n = 1'b1;
    mdio_i = 1'b1;
    #10;
    frame_check("post_rst", 32, 2'b10, 5'd1, 5'd2, 2'b10, 16'h0000, 1, 16'h0141);

    // Random frames against the register-level model (starts from reset state).
    m_ctrl   = 16'h1140;
    m_scr[0] = '0; m_scr[1] = '0; m_scr[2] = '0; m_scr[3] = '0;
    m_err    = '0;
    m_pulses = 1;
    for (int n = 0; n < 24; n++) begin
      status_in = 16'($urandom);
      x     = int'($urandom_range(0, 7));
      r_op  = (x == 0) ? (($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00) :
              (x < 4)  ? 2'b10 : 2'b01;
      x     = int'($urandom_range(0, 4));
      r_phy = (x == 0) ? 5'd0 : ((x == 4) ? 5'd5 : 5'd1);
      r_rg  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
      r_ta  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'b10;
      r_wd  = 16'($urandom);
      r_drv = 1'b0;
      r_exp = 16'h0000;
      if (r_op == 2'b10) begin
        r_drv = (r_phy == 5'd1);
        r_exp = mread(r_rg, status_in);
      end else if (r_op == 2'b01) begin
        if (r_ta != 2'b10) begin
          if (m_err != 8'hFF) m_err = m_err + 8'd1;
        end else if (r_phy == 5'd1 || r_phy == 5'd0) begin
          if (r_rg == 5'd0) begin
            m_ctrl = {1'b0, r_wd[14:0]};
            if (r_wd[15]) m_pulses++;
          end else if (r_rg >= 5'd4 && r_rg <= 5'd7) begin
            m_scr[r_rg[1:0]] = r_wd;
          end
        end
      end else begin
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
      end
      frame_check($sformatf("rnd%0d", n), 32, r_op, r_phy, r_rg, r_ta, r_wd, r_drv, r_exp);
      check_state($sformatf("rnd%0d", n), m_err, m_ctrl,
                  {m_scr[3], m_scr[2], m_scr[1], m_scr[0]}, m_pulses);
    end

    check("srst_width", 64'(srst_long), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdio_phy_responder.md
Name: mdio_phy_responder

Overview:
- Clause-22 MDIO management responder (PHY side) for the EMAC1 management bus; the HPS EMAC acts as station manager.
- Fabric logic oversamples MDC and MDIO on the system clock. The block decodes read and write frames addressed to its PHY address and serves a small 16-bit register file.
- Register file holds: control (with self-clearing soft reset), status from fabric, two read-only PHY ID registers, and general-purpose scratch registers.
- Sits between the HPS EMAC1 MDIO pins (mdc, mdo_o, mdo_o_e, mdi_i) and the SGMII PCS/status logic.

Parameters:
- PHY_ADDR, 5'd1, PHY address this responder answers to.
- BCAST_EN, 1, 1 = also answer PHYAD 0 (writes only; reads at PHYAD 0 are ignored).
- PHY_ID1, 16'h0141, value returned for register 2.
- PHY_ID2, 16'h0DD1, value returned for register 3.
- PREAMBLE_LEN, 32, consecutive 1 bits required before ST.
- TIMEOUT_CYC, 4096, clk cycles without an MDC rising edge mid-frame before abort.

Ports:
- clk_clk, input, 1, system clock (100 MHz); MDC must be at most clk/8.
- reset_reset_n, input, 1, asynchronous active-low reset.
- mdc, input, 1, management clock from the EMAC, asynchronous to clk_clk.
- mdio_i, input, 1, MDIO line as seen at the pin.
- mdio_o, output, 1, MDIO drive value.
- mdio_oe, output, 1, MDIO drive enable; 1 = drive.
- status_in, input, 16, live value returned for register 1.
- ctrl_out, output, 16, register 0 contents.
- soft_reset, output, 1, one-clk pulse when register 0 bit 15 is written as 1.
- scratch_out, output, 64, registers 4..7 concatenated, register 4 in bits [15:0].
- err_count, output, 8, count of aborted frames; saturates at 255.

Behaviour:
- Reset values: mdio_oe=0, mdio_o=1, ctrl_out=16'h1140, scratch=0, soft_reset=0, err_count=0, FSM=IDLE.
- Synchronisers: mdc and mdio_i each pass through a 2-flop synchroniser. An MDC rising edge ("edge") is detected as sync==1 and previous==0.
- All bit sampling and all drive changes occur only on the clk cycle of an edge.
- States: IDLE, ST1, OP, PHYAD, REGAD, TA, WDATA, RDATA.
- IDLE:
  - Count consecutive sampled 1s, saturating at PREAMBLE_LEN.
  - A sampled 0 when count>=PREAMBLE_LEN goes to ST1; otherwise the count clears.
- ST1: sample 1 goes to OP; sample 0 aborts.
- OP: 2 bits. 10 = read, 01 = write; 00 or 11 aborts.
- PHYAD: 5 bits, MSB first. REGAD: 5 bits, MSB first. Then go to TA.
- match = (PHYAD==PHY_ADDR) or (BCAST_EN and PHYAD==0 and op==write).
- Read frame with match:
  - The edge sampling the last REGAD bit keeps oe=0 (TA bit 1 is Z).
  - The next edge sets oe=1, mdio_o=0 (TA bit 2).
  - The following 16 edges drive data[15] down to data[0].
  - The edge after data[0] sets oe=0, mdio_o=1 and returns to IDLE.
  - Read data is latched at the REGAD-complete edge.
  - Register map for reads: reg0=ctrl, reg1=status_in, reg2=PHY_ID1, reg3=PHY_ID2, reg4..7=scratch, reg8..31=0.
- Write frame: TA must sample 1 then 0, else abort. Then shift 16 bits into WDATA.
- Write commit: on the 16th data edge, if match, commit and return to IDLE.
  - reg0: bit15 is self-clearing. Store bits[14:0] and pulse soft_reset for 1 clk; bit15 always reads 0.
  - reg1..3 and reg8..31: writes are ignored.
  - reg4..7: written as given.
- Non-matching frame: the FSM tracks the frame to completion, never drives the line and never writes.
- Abort: go to IDLE and set oe=0 in the same cycle. err_count increments by 1, saturating.
  - Abort causes: bad ST, bad OP, bad write TA, or timeout.
  - Timeout: in any non-IDLE state, TIMEOUT_CYC clk cycles without an edge.
- Preamble after abort: the preamble counter restarts from 0, so a new frame needs a full preamble again.
- A frame that completes normally also returns to IDLE with preamble count 0.
- mdio_i is ignored while oe=1; no loopback checking is done.
- Asynchronous reset mid-frame: all state returns to reset values immediately, and oe drops without waiting for a clock.

Test Plan:
- Write reg4: 32x1 preamble, ST 01, OP 01, PHYAD 1, REGAD 4, TA 10, data 16'hA5C3 -> scratch_out[15:0]=16'hA5C3; oe stays 0 throughout the frame.
- Read reg2 at PHYAD 1 -> oe=0 during TA bit 1, mdio_o=0 on TA bit 2, then serial 16'h0141 MSB first; oe=0 on the edge after the last data bit.
- Write reg0 data 16'h8000 -> soft_reset pulses 1 clk; a following read of reg0 returns 16'h0000.
- Broadcast write reg5=16'h1234 at PHYAD 0 with BCAST_EN=1 -> scratch_out[31:16]=16'h1234; read at PHYAD 0 -> oe never asserts.
- Error paths:
  - OP 11 -> err_count=1.
  - Write TA 11 -> err_count=2.
  - MDC stopped for 5000 clk mid-PHYAD -> err_count=3, FSM back in IDLE.
  - A 31-bit preamble followed by a valid frame -> no response.
- Assert reset_reset_n low during read data bit 7 -> mdio_oe=0 immediately and all outputs at reset values; the next valid read after reset responds correctly.
